// File: rtl/fc_out_serializer_if.sv
// Layer-output handshake bundle between a producer of full FC result
// vectors, the serializer, and the next layer's input collector.
// Both channels use valid/ready: a transfer happens on the rising edge
// where valid and ready are both high; once valid is raised its payload
// holds until that edge, and ready never depends on valid.
interface fc_out_serializer_if #(
   parameter int WIDTH = 8,
   parameter int N     = 84,
   parameter int ACC_W = WIDTH*2 + $clog2(N)
);
   localparam int IDX_W = $clog2(N);

   // vector input channel
   logic                 in_valid;
   logic                 in_ready;
   logic [N*ACC_W-1:0]   in_data;

   // beat output channel
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [IDX_W-1:0]     out_idx;
   logic                 out_last;

   // driver/observer side (producer of vectors, consumer of beats)
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   // serializer side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/fc_out_serializer.sv
// Captures a whole FC layer result vector in one handshake, requantizes
// each entry (rounding right shift, then clamp to the positive signed
// range) and streams the entries one beat per cycle with index and last.
// Back-to-back frames are accepted on the last beat with no bubble.
module fc_out_serializer #(
   parameter int WIDTH = 8,
   parameter int N     = 84,
   parameter int ACC_W = WIDTH*2 + $clog2(N),
   parameter int SHIFT = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   fc_out_serializer_if.slave  io,
   output logic                dbg_state   // 0 = IDLE, 1 = STREAM
);
   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   // Rounding constant: half an output LSB; zero when no shift is applied.
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [ACC_W:0] RND =
      (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : '0;
   // Largest positive value of a signed WIDTH-bit activation.
   localparam logic [ACC_W:0] SAT = (ACC_W+1)'((1 << (WIDTH - 1)) - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [ACC_W-1:0]  bank [N];
   logic [WIDTH-1:0]  out_data_q;
   logic              out_last_q;

   logic              at_last;
   logic [IDX_W-1:0]  idx_nxt;
   logic              in_fire;

   // Negative inputs (impossible after ReLU) map to 0; the sum is one bit
   // wider than the accumulator so the rounding add cannot wrap.
   function automatic logic [WIDTH-1:0] requant(input logic [ACC_W-1:0] v);
      logic [ACC_W:0] t;
      t = ({1'b0, v} + RND) >> SHIFT;
      if (v[ACC_W-1])
         return '0;
      else if (t > SAT)
         return SAT[WIDTH-1:0];
      else
         return t[WIDTH-1:0];
   endfunction

   assign at_last = (idx == LAST_IDX);
   assign idx_nxt = idx + 1'b1;

   // Ready in IDLE, or on the cycle the last beat is being taken.
   assign io.in_ready = (state == IDLE) |
                        ((state == STREAM) & at_last & io.out_ready);
   assign in_fire     = io.in_valid & io.in_ready;

   assign io.out_valid = (state == STREAM);
   assign io.out_data  = out_data_q;
   assign io.out_idx   = idx;
   assign io.out_last  = out_last_q;
   assign dbg_state    = state;

   // Capture bank: written only on the input handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) bank[k] <= '0;
      end else if (in_fire) begin
         for (int k = 0; k < N; k++) bank[k] <= io.in_data[k*ACC_W +: ACC_W];
      end
   end

   // Frame sequencer: beat index, state and registered beat payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io.in_valid) begin
                  state      <= STREAM;
                  idx        <= '0;
                  out_data_q <= requant(io.in_data[ACC_W-1:0]);
                  out_last_q <= (N == 1);
               end
            end
            STREAM: begin
               if (io.out_ready) begin
                  if (at_last) begin
                     if (io.in_valid) begin
                        // next frame starts immediately, no bubble
                        idx        <= '0;
                        out_data_q <= requant(io.in_data[ACC_W-1:0]);
                        out_last_q <= (N == 1);
                     end else begin
                        state      <= IDLE;
                        idx        <= '0;
                        out_data_q <= '0;
                        out_last_q <= 1'b0;
                     end
                  end else begin
                     idx        <= idx_nxt;
                     out_data_q <= requant(bank[idx_nxt]);
                     out_last_q <= (idx_nxt == LAST_IDX);
                  end
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end
endmodule
